gate_truth_checker: RTL and testbench

Self-checking stimulus/response stage that sits around a two-input basic gate (nand_gate by default). It drives the gate's a/b inputs through all four input combinations and holds each for a programmable settle time. It samples the gate output and compares it against an expected truth table. A pass/fail result and a per-row error mask are returned through a start/done handshake.

---
 rtl/gate_truth_checker.sv | 157 +++++++++++++++
 tb/tb_gate_truth_checker.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/gate_truth_checker.sv
// gate_truth_checker
// Drives a two-input gate through rows 00, 01, 10, 11. Each row is held for
// HOLD_CYCLES settle cycles plus one sample cycle. The gate output is checked
// against EXP_TT, and the result comes back through a start/busy/done
// handshake.
// Optional macro GATE_CHK_STABLE_EN: y_in is also checked on the last settle
// cycle of every row, which catches outputs that settle late or glitch.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start, a=b=0, previous result held
// DRIVE  | {a,b}=row, settle counter running
// SAMPLE | {a,b}=row, y_in compared with EXP_TT[row] on exit
// FINISH | one-cycle done pulse, pass/err_mask final, a=b=0
module gate_truth_checker #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [3:0] EXP_TT      = 4'b0111
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("gate_truth_checker: HOLD_CYCLES must be in 1..255");
        end
    endgenerate

    localparam logic [7:0] CNT_LAST = 8'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t     state, state_nx;
    logic [1:0] row, row_nx;
    logic [7:0] cnt, cnt_nx;
    logic       a_nx, b_nx, busy_nx, done_nx, pass_nx;
    logic [3:0] err_nx;

    logic       mismatch;
    logic [3:0] row_bit;
    logic       last_drive;
    logic       stable_hit;

    assign mismatch   = (y_in != EXP_TT[row]);
    assign row_bit    = 4'b0001 << row;
    assign last_drive = (cnt == CNT_LAST);

`ifdef GATE_CHK_STABLE_EN
    assign stable_hit = (state == DRIVE) && last_drive && mismatch;
`else
    assign stable_hit = 1'b0;
`endif

    // state register plus all registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            row      <= 2'd0;
            cnt      <= 8'd0;
            a        <= 1'b0;
            b        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_mask <= 4'd0;
        end else begin
            state    <= state_nx;
            row      <= row_nx;
            cnt      <= cnt_nx;
            a        <= a_nx;
            b        <= b_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pass     <= pass_nx;
            err_mask <= err_nx;
        end
    end

    // next-state decode
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = DRIVE;
            DRIVE:   if (last_drive) state_nx = SAMPLE;
            SAMPLE:  state_nx = (row == 2'd3) ? FINISH : DRIVE;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // next values of the registered outputs, row and settle counter
    always_comb begin
        row_nx  = row;
        cnt_nx  = cnt;
        a_nx    = a;
        b_nx    = b;
        busy_nx = busy;
        done_nx = 1'b0;
        pass_nx = pass;
        err_nx  = err_mask;
        case (state)
            IDLE: begin
                a_nx    = 1'b0;
                b_nx    = 1'b0;
                busy_nx = 1'b0;
                if (start) begin
                    row_nx  = 2'd0;
                    cnt_nx  = 8'd0;
                    err_nx  = 4'd0;
                    pass_nx = 1'b0;
                    busy_nx = 1'b1;
                end
            end
            DRIVE: begin
                cnt_nx = cnt + 8'd1;
                if (stable_hit) err_nx = err_mask | row_bit;
            end
            SAMPLE: begin
                if (mismatch) err_nx = err_mask | row_bit;
                if (row != 2'd3) begin
                    row_nx        = row + 2'd1;
                    cnt_nx        = 8'd0;
                    {a_nx, b_nx}  = row + 2'd1;
                end else begin
                    done_nx = 1'b1;
                    busy_nx = 1'b0;
                    pass_nx = ~|(err_mask | (mismatch ? row_bit : 4'd0));
                    a_nx    = 1'b0;
                    b_nx    = 1'b0;
                end
            end
            FINISH: begin
                a_nx    = 1'b0;
                b_nx    = 1'b0;
                busy_nx = 1'b0;
            end
            default: begin
                a_nx    = 1'b0;
                b_nx    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: the gate under check is a 4-entry lookup
// table (plus an optional inversion "glitch"), and a cycle-count model
// derives every expected output from the number of edges since acceptance.
module tb_gate_truth_checker;

    localparam int         H   = 4;
    localparam logic [3:0] EXP = 4'b0111;
    localparam int         N   = 4 * (H + 1);

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       y_in;
    logic       a, b, busy, done, pass;
    logic [3:0] err_mask;

    logic [3:0] gfunc;
    logic       glitch;

    int checks = 0;
    int errors = 0;

    gate_truth_checker #(.HOLD_CYCLES(H), .EXP_TT(EXP)) dut (
        .clk(clk), .rst(rst), .start(start), .y_in(y_in),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .err_mask(err_mask)
    );

    always #5 clk = ~clk;

    assign y_in = gfunc[{a, b}] ^ glitch;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: position in a run is just edges since acceptance
    bit         m_active, m_finish;
    int         m_k;
    logic       m_a, m_b, m_busy, m_done, m_pass;
    logic [3:0] m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 0; m_finish = 0; m_k = 0;
            m_a = 0; m_b = 0; m_busy = 0; m_done = 0; m_pass = 0; m_err = 0;
        end else if (m_active) begin
            int r, pos;
            bit look;
            r    = m_k / (H + 1);
            pos  = m_k % (H + 1);
            look = (pos == H);
`ifdef GATE_CHK_STABLE_EN
            if (pos == H - 1) look = 1;
`endif
            if (look && (y_in !== EXP[r])) m_err[r] = 1'b1;
            m_k++;
            if (m_k == N) begin
                m_active = 0; m_finish = 1;
                m_done = 1; m_busy = 0; m_a = 0; m_b = 0;
                m_pass = (m_err == 4'd0);
            end else begin
                r = m_k / (H + 1);
                m_a = r[1]; m_b = r[0];
            end
        end else if (m_finish) begin
            m_finish = 0; m_done = 0;
        end else if (start) begin
            m_active = 1; m_k = 0;
            m_err = 0; m_pass = 0; m_busy = 1; m_a = 0; m_b = 0;
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("a", a, m_a);
            chk("b", b, m_b);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("pass", pass, m_pass);
            chk("err_mask", err_mask, m_err);
        end
    end

    task automatic start_pulse();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    // counts edges after the accepting edge until done; -1 on timeout
    task automatic wait_done(input int extra_at, input int gl_at, output int lat);
        bit got;
        got = 0;
        lat = -1;
        for (int n = 1; n <= 60 && !got; n++) begin
            @(posedge clk); #1;
            if (n == extra_at)     start  = 1'b1;
            if (n == extra_at + 1) start  = 1'b0;
            if (n == gl_at)        glitch = 1'b1;
            if (n == gl_at + 1)    glitch = 1'b0;
            if (done) begin
                lat = n;
                got = 1;
            end
        end
        start  = 1'b0;
        glitch = 1'b0;
    endtask

    initial begin
        int lat;
        rst = 1'b1; start = 1'b0; glitch = 1'b0; gfunc = 4'b0111;
        #3;
        chk("rst_a", a, 0); chk("rst_b", b, 0); chk("rst_busy", busy, 0);
        chk("rst_done", done, 0); chk("rst_pass", pass, 0); chk("rst_err", err_mask, 0);
        @(negedge clk); @(negedge clk); rst = 1'b0;

        // 1: correct NAND
        start_pulse();
        wait_done(-5, -5, lat);
        chk("t1_latency", lat, N);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_mask, 4'b0000);

        // 2: AND gate
        gfunc = 4'b1000;
        start_pulse();
        wait_done(-5, -5, lat);
        chk("t2_latency", lat, N);
        chk("t2_pass", pass, 0);
        chk("t2_err", err_mask, 4'b1111);

        // 3: stuck-at-1, then restart clears result
        gfunc = 4'b1111;
        start_pulse();
        wait_done(-5, -5, lat);
        chk("t3_pass", pass, 0);
        chk("t3_err", err_mask, 4'b1000);
        gfunc = 4'b0111;
        start_pulse();
        chk("t3_restart_err", err_mask, 4'b0000);
        chk("t3_restart_busy", busy, 1);
        wait_done(-5, -5, lat);
        chk("t3b_latency", lat, N);

        // 4: extra start mid-run ignored; held start gives back-to-back runs
        start_pulse();
        wait_done(6, -5, lat);
        chk("t4_latency_extra", lat, N);
        @(posedge clk); #2 start = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) break;
        end
        @(posedge clk); #1 chk("t4_finish_to_idle_busy", busy, 0);
        @(posedge clk); #1 chk("t4_reaccept_busy", busy, 1);
        wait_done(-5, -5, lat);
        chk("t4_second_latency", lat, N);

        // 5: reset mid-run, between edges
        gfunc = 4'b1000;
        start_pulse();
        repeat (9) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk("t5_a", a, 0); chk("t5_b", b, 0); chk("t5_busy", busy, 0);
        chk("t5_done", done, 0); chk("t5_pass", pass, 0); chk("t5_err", err_mask, 0);
        @(negedge clk); rst = 1'b0;
        gfunc = 4'b0111;
        repeat (3) @(negedge clk);
        chk("t5_no_done", done, 0);
        start_pulse();
        wait_done(-5, -5, lat);
        chk("t5_latency", lat, N);
        chk("t5_pass_after", pass, 1);

        // 6: glitch only during last settle cycle of row 01
        start_pulse();
        wait_done(-5, 2 * H, lat);
        chk("t6_latency", lat, N);
`ifdef GATE_CHK_STABLE_EN
        chk("t6_err", err_mask, 4'b0010);
        chk("t6_pass", pass, 0);
`else
        chk("t6_err", err_mask, 4'b0000);
        chk("t6_pass", pass, 1);
`endif

        // random gates, gaps, stray starts and glitches
        for (int i = 0; i < 30; i++) begin
            int ex, gl;
            gfunc = 4'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            ex = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 15)) : -5;
            gl = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 18)) : -5;
            start_pulse();
            wait_done(ex, gl, lat);
            chk("rand_latency", lat, N);
        end

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
